// File: rtl/decode_queue.sv
// decode_queue: RV32I decoder feeding a DEPTH-entry in-order FIFO of decoded instructions.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W = 32,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic [PC_W-1:0]  pc_in,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic             flush,
    input  logic             ready_out,
    output logic             valid_out,
    output logic [PC_W-1:0]  pc_out,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [31:0]      imm,
    output logic [2:0]       ALUOp,
    output logic [6:0]       opcode,
    output logic             illegal,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    // ALUOp classes: memory/address add, branch compare, register, immediate, jump, lui, auipc, illegal
    localparam logic [2:0] ALU_MEM = 3'd0, ALU_BR = 3'd1, ALU_R = 3'd2, ALU_I = 3'd3,
                           ALU_JMP = 3'd4, ALU_LUI = 3'd5, ALU_AUIPC = 3'd6, ALU_ILL = 3'd7;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [31:0]     imm;
        logic [2:0]      alu_op;
        logic [6:0]      opcode;
        logic            illegal;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          dec;
    entry_t          head_e;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic            push;
    logic            pop;

    always_comb begin
        dec = '0;
        dec.pc = pc_in;
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        dec.rd = instr[11:7];
        dec.opcode = instr[6:0];
        case (instr[6:0])
            7'b0110011: dec.alu_op = ALU_R;
            7'b0010011: begin dec.alu_op = ALU_I; dec.imm = {{20{instr[31]}}, instr[31:20]}; end
            7'b0000011: begin dec.alu_op = ALU_MEM; dec.imm = {{20{instr[31]}}, instr[31:20]}; end
            7'b1100111: begin dec.alu_op = ALU_JMP; dec.imm = {{20{instr[31]}}, instr[31:20]}; end
            7'b0100011: begin dec.alu_op = ALU_MEM; dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]}; end
            7'b1100011: begin
                dec.alu_op = ALU_BR;
                dec.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            7'b0110111: begin dec.alu_op = ALU_LUI; dec.imm = {instr[31:12], 12'b0}; end
            7'b0010111: begin dec.alu_op = ALU_AUIPC; dec.imm = {instr[31:12], 12'b0}; end
            7'b1101111: begin
                dec.alu_op = ALU_JMP;
                dec.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: begin dec.alu_op = ALU_ILL; dec.illegal = 1'b1; end
        endcase
    end

    // ready_out feeds ready_in combinationally so a full queue can push and pop together
    assign valid_out = count != '0;
    assign ready_in = (count < CNT_W'(DEPTH)) || ready_out;
    assign push = valid_in && ready_in;
    assign pop = valid_out && ready_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            head <= '0;
            tail <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            count <= '0;
            head <= '0;
            tail <= '0;
        end else begin
            if (push) begin
                mem[tail] <= dec;
                tail <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign head_e = valid_out ? mem[head] : '0;
    assign pc_out = head_e.pc;
    assign rs1 = head_e.rs1;
    assign rs2 = head_e.rs2;
    assign rd = head_e.rd;
    assign imm = head_e.imm;
    assign ALUOp = head_e.alu_op;
    assign opcode = head_e.opcode;
    assign illegal = head_e.illegal;
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: scoreboard bench for decode_queue using hand-decoded instruction vectors.
module tb_decode_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             reset;
    logic [31:0]      instr;
    logic [31:0]      pc_in;
    logic             valid_in;
    logic             ready_in;
    logic             flush;
    logic             ready_out;
    logic             valid_out;
    logic [31:0]      pc_out;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [31:0]      imm;
    logic [2:0]       ALUOp;
    logic [6:0]       opcode;
    logic             illegal;
    logic [CNT_W-1:0] count;

    decode_queue #(.DEPTH(DEPTH), .PC_W(32)) dut (
        .clk(clk), .reset(reset), .instr(instr), .pc_in(pc_in), .valid_in(valid_in),
        .ready_in(ready_in), .flush(flush), .ready_out(ready_out), .valid_out(valid_out),
        .pc_out(pc_out), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .ALUOp(ALUOp),
        .opcode(opcode), .illegal(illegal), .count(count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  alu;
        logic [6:0]  op;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  alu;
        logic [6:0]  op;
        logic        ill;
    } vec_t;

    // Hand-decoded vectors: addi, sw, all-ones, add, lui, beq, jal, auipc, jalr, lw, custom-0
    vec_t tbl [11] = '{
        '{32'hFFD08293, 5'd1,  5'd29, 5'd5,  32'hFFFFFFFD, 3'd3, 7'h13, 1'b0},
        '{32'h0021A423, 5'd3,  5'd2,  5'd8,  32'h00000008, 3'd0, 7'h23, 1'b0},
        '{32'hFFFFFFFF, 5'd31, 5'd31, 5'd31, 32'h00000000, 3'd7, 7'h7F, 1'b1},
        '{32'h002081B3, 5'd1,  5'd2,  5'd3,  32'h00000000, 3'd2, 7'h33, 1'b0},
        '{32'h12345537, 5'd8,  5'd3,  5'd10, 32'h12345000, 3'd5, 7'h37, 1'b0},
        '{32'hFE208EE3, 5'd1,  5'd2,  5'd29, 32'hFFFFFFFC, 3'd1, 7'h63, 1'b0},
        '{32'h008000EF, 5'd0,  5'd8,  5'd1,  32'h00000008, 3'd4, 7'h6F, 1'b0},
        '{32'hFFFFF117, 5'd31, 5'd31, 5'd2,  32'hFFFFF000, 3'd6, 7'h17, 1'b0},
        '{32'h00008067, 5'd1,  5'd0,  5'd0,  32'h00000000, 3'd4, 7'h67, 1'b0},
        '{32'hFFF3A303, 5'd7,  5'd31, 5'd6,  32'hFFFFFFFF, 3'd0, 7'h03, 1'b0},
        '{32'h0000000B, 5'd0,  5'd0,  5'd0,  32'h00000000, 3'd7, 7'h0B, 1'b1}
    };

    exp_t cur;
    exp_t q[$];
    exp_t act;
    int   checks;
    int   failures;
    int   pops;
    logic mr;

    assign act = {pc_out, rs1, rs2, rd, imm, ALUOp, opcode, illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, a, e, $time);
        end
    endtask

    // Monitor: compares state and head entry mid-cycle, then advances the scoreboard for the coming edge
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            check("reset_count", 128'(count), 0);
            check("reset_valid", 128'(valid_out), 0);
            check("reset_data", 128'(act), 0);
        end else begin
            mr = q.size() < DEPTH || ready_out;
            check("count", 128'(count), 128'(q.size()));
            check("count_max", 128'(count <= DEPTH), 1);
            check("valid_out", 128'(valid_out), 128'(q.size() != 0));
            check("ready_in", 128'(ready_in), 128'(mr));
            if (q.size() != 0) check("head", 128'(act), 128'(q[0]));
            else check("idle_zero", 128'(act), 0);
            if (flush) q.delete();
            else begin
                if (q.size() != 0 && ready_out) begin
                    void'(q.pop_front());
                    pops++;
                end
                if (valid_in && mr) q.push_back(cur);
            end
        end
    end

    task automatic step(input logic v, input int idx, input logic [31:0] pc, input logic ro, input logic fl);
        instr = tbl[idx].ins;
        pc_in = pc;
        valid_in = v;
        ready_out = ro;
        flush = fl;
        cur = '{pc, tbl[idx].rs1, tbl[idx].rs2, tbl[idx].rd, tbl[idx].imm, tbl[idx].alu, tbl[idx].op, tbl[idx].ill};
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        pops = 0;
        reset = 1'b1;
        valid_in = 1'b0;
        flush = 1'b0;
        ready_out = 1'b0;
        instr = '0;
        pc_in = '0;
        cur = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step(1, 0, 32'h100, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 1, 32'h104, 1, 0);
        step(1, 2, 32'h108, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 3 + i, 32'(i * 4), 0, 0);
        step(1, 7, 32'h10, 1, 0);
        repeat (6) step(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 4 + i, 32'h200 + 32'(i * 4), 0, 0);
        step(1, 9, 32'h2FC, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 8, 32'h300, 0, 0);
        step(1, 9, 32'h304, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("async_count", 128'(count), 0);
        check("async_valid", 128'(valid_out), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        step(1, 10, 32'h400, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 7, int'($urandom_range(0, 10)), $urandom,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
        repeat (6) step(0, 0, 0, 1, 0);
        check("drained", 128'(count), 0);
        check("pops_seen", 128'(pops > 500), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
